// File: rtl/tour_pred_pkg.sv
// Shared encodings, defaults and helpers for the tournament predictor chooser/history controller.
package tour_pred_pkg;

   localparam int CH_IDX_W_DEF = 6;
   localparam int GHR_W_DEF    = 8;

   // Chooser encoding: MSB set means the global predictor is selected.
   localparam logic [1:0] CH_STRONG_LOC = 2'b00;
   localparam logic [1:0] CH_WEAK_LOC   = 2'b01;
   localparam logic [1:0] CH_WEAK_GLO   = 2'b10;
   localparam logic [1:0] CH_STRONG_GLO = 2'b11;
   localparam logic [1:0] CH_INIT_DEF   = CH_WEAK_LOC;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } ctrlState_e;

   function automatic logic [1:0] chooserStep(input logic [1:0] cur, input logic towardGlo);
      logic [1:0] nxt;
      nxt = cur;
      if (towardGlo) begin
         if (cur != CH_STRONG_GLO) nxt = cur + 2'd1;
      end else begin
         if (cur != CH_STRONG_LOC) nxt = cur - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/choice_table.sv
// PC-indexed 2-bit chooser storage: async read for D, sync saturating train write for M,
// and an init-walk port that takes priority over training.
module choice_table
   import tour_pred_pkg::*;
#(
   parameter int         IDX_W    = CH_IDX_W_DEF,
   parameter logic [1:0] INIT_VAL = CH_INIT_DEF
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] rdIdx,
   output logic [1:0]       rdData,
   input  logic             initEn,
   input  logic [IDX_W-1:0] initIdx,
   input  logic             trainEn,
   input  logic [IDX_W-1:0] trainIdx,
   input  logic             trainTowardGlo
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [1:0] mem_q [0:DEPTH-1];
   logic [1:0] trainNext;

   assign rdData = mem_q[rdIdx];

   always_comb begin
      trainNext = chooserStep(mem_q[trainIdx], trainTowardGlo);
   end

   // No reset on the array itself; the controller's init walk rewrites every entry.
   always_ff @(posedge clk) begin
      if (initEn) begin
         mem_q[initIdx] <= INIT_VAL;
      end else if (trainEn) begin
         mem_q[trainIdx] <= trainNext;
      end
   end

endmodule

// File: rtl/tour_choice_ctrl.sv
// Tournament chooser/history controller: D-stage selection, speculative GHR with M-stage
// repair, chooser training, post-reset table init walk and a saturating mispredict counter.
module tour_choice_ctrl
   import tour_pred_pkg::*;
#(
   parameter int         CH_IDX_W = CH_IDX_W_DEF,
   parameter int         GHR_W    = GHR_W_DEF,
   parameter logic [1:0] CH_INIT  = CH_INIT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallD,
   input  logic             flushD,
   input  logic             branchD,
   input  logic [31:0]      pcD,
   input  logic             pred_takeD_loc,
   input  logic             pred_takeD_glo,
   output logic             pred_takeD,
   output logic             choice_gloD,
   output logic [GHR_W-1:0] ghrD,
   input  logic             branchM,
   input  logic [31:0]      pcM,
   input  logic             actual_takeM,
   input  logic             pred_takeM,
   input  logic             pred_locM,
   input  logic             pred_gloM,
   input  logic [GHR_W-1:0] ghr_ckptM,
   output logic             pred_wrongM,
   output logic             init_busy,
   output logic [15:0]      mispred_cnt
);

   localparam logic [CH_IDX_W-1:0] LAST_IDX = '1;

   ctrlState_e          state_q, state_d;
   logic [CH_IDX_W-1:0] ptr_q, ptr_d;
   logic [GHR_W-1:0]    ghr_q;
   logic [15:0]         cnt_q;

   logic                run;
   logic [1:0]          chooserD;
   logic                trainEn;
   logic                unusedBits;

   assign run = (state_q == ST_RUN) & ~rst;

   choice_table #(
      .IDX_W    (CH_IDX_W),
      .INIT_VAL (CH_INIT)
   ) u_table (
      .clk            (clk),
      .rdIdx          (pcD[CH_IDX_W+1:2]),
      .rdData         (chooserD),
      .initEn         ((state_q == ST_INIT) & ~rst),
      .initIdx        (ptr_q),
      .trainEn        (trainEn),
      .trainIdx       (pcM[CH_IDX_W+1:2]),
      .trainTowardGlo (pred_gloM == actual_takeM)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_INIT: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_IDX) state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign init_busy   = rst | (state_q == ST_INIT);
   assign choice_gloD = run & chooserD[1];
   assign pred_takeD  = run & branchD & (chooserD[1] ? pred_takeD_glo : pred_takeD_loc);
   assign ghrD        = ghr_q;
   assign pred_wrongM = run & branchM & (pred_takeM != actual_takeM);
   assign trainEn     = run & branchM & (pred_locM != pred_gloM);
   assign mispred_cnt = cnt_q;

   // A mispredict in M means the D-stage branch is on the wrong path, so repair wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q <= '0;
      end else if (pred_wrongM) begin
         ghr_q <= {ghr_ckptM[GHR_W-2:0], actual_takeM};
      end else if (run & branchD & ~stallD & ~flushD) begin
         ghr_q <= {ghr_q[GHR_W-2:0], pred_takeD};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (pred_wrongM && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign unusedBits = ^{pcD[31:CH_IDX_W+2], pcD[1:0], pcM[31:CH_IDX_W+2], pcM[1:0],
                         ghr_ckptM[GHR_W-1]};

endmodule
